// File: rtl/ir_cmd_scheduler_if.sv
// ir_cmd_scheduler_if: IR command input, power/LED status and queued command valid/ready bundle.
interface ir_cmd_scheduler_if #(
    parameter int DEPTH = 4
);
    logic [7:0]             ir_cmd;
    logic                   ir_valid;
    logic                   power_on;
    logic                   led;
    logic [7:0]             cmd_data;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output ir_cmd, ir_valid, cmd_ready,
        input  power_on, led, cmd_data, cmd_valid, overflow, level
    );

    modport slave (
        input  ir_cmd, ir_valid, cmd_ready,
        output power_on, led, cmd_data, cmd_valid, overflow, level
    );
endinterface

// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: repeat-filters IR commands, owns power state, queues commands while ON.
module ir_cmd_scheduler #(
    parameter int          DEPTH       = 4,
    parameter int          HOLDOFF_CYC = 5_000_000,
    parameter logic [7:0]  POWER_CMD   = 8'h80
) (
    input logic             clk,
    input logic             rst_n,
    ir_cmd_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic {STANDBY, ON} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    last_code;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level, level_nx;
    logic          valid_q, overflow_q;
    logic          dup, accept, is_pwr, push, pop, drop, flush, full;

    always_comb begin
        dup      = bus.ir_valid && bus.ir_cmd == last_code && hold_cnt != '0;
        accept   = bus.ir_valid && !dup;
        is_pwr   = bus.ir_cmd == POWER_CMD;
        full     = level == (AW+1)'(DEPTH);
        state_nx = (accept && is_pwr) ? (state == ON ? STANDBY : ON) : state;
        flush    = state == ON && state_nx == STANDBY;
        push     = accept && !is_pwr && state == ON && !full;
        drop     = accept && !is_pwr && state == ON && full;
        // a pop coinciding with power-off is swallowed by the flush
        pop      = valid_q && bus.cmd_ready && !flush;
        level_nx = flush ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STANDBY;
            hold_cnt   <= '0;
            last_code  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state      <= state_nx;
            // any strobe reloads the window, so a held key never leaks through
            hold_cnt   <= bus.ir_valid ? CW'(HOLDOFF_CYC) : (hold_cnt != '0 ? hold_cnt - 1'b1 : '0);
            last_code  <= accept ? bus.ir_cmd : last_code;
            overflow_q <= drop;
            if (push) mem[wr_ptr] <= bus.ir_cmd;
            wr_ptr     <= flush ? '0 : wr_ptr + AW'(push);
            rd_ptr     <= flush ? '0 : rd_ptr + AW'(pop);
            level      <= level_nx;
            valid_q    <= level_nx != '0;
        end
    end

    assign bus.power_on  = state == ON;
    assign bus.led       = state != ON;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_data  = mem[rd_ptr];
    assign bus.overflow  = overflow_q;
    assign bus.level     = level;
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb_ir_cmd_scheduler: queue-based reference model checked every cycle, plus directed literal checks.
module tb_ir_cmd_scheduler;
    localparam int         DEPTH = 4;
    localparam int         HOLD  = 8;
    localparam logic [7:0] PWR   = 8'h80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    ir_cmd_scheduler_if #(.DEPTH(DEPTH)) bus ();

    ir_cmd_scheduler #(.DEPTH(DEPTH), .HOLDOFF_CYC(HOLD), .POWER_CMD(PWR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: time-stamped holdoff window, plain queue for the FIFO
    logic [7:0] q[$];
    logic       m_power = 1'b0;
    logic       m_ovf = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         cyc = 0;
    int         reload_cyc = -1000;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_power = 1'b0;
            m_ovf = 1'b0;
            m_last = 8'h00;
            reload_cyc = -1000;
        end else begin
            logic popped, dupl;
            popped = m_power && q.size() > 0 && bus.cmd_ready;
            m_ovf = 1'b0;
            if (bus.ir_valid) begin
                dupl = bus.ir_cmd == m_last && (cyc - reload_cyc) <= HOLD;
                reload_cyc = cyc;
                if (!dupl) begin
                    m_last = bus.ir_cmd;
                    if (bus.ir_cmd == PWR) begin
                        if (m_power) begin
                            q.delete();
                            popped = 1'b0;
                        end
                        m_power = !m_power;
                    end else if (m_power) begin
                        if (q.size() == DEPTH) m_ovf = 1'b1;
                        else q.push_back(bus.ir_cmd);
                    end
                end
            end
            if (popped) void'(q.pop_front());
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("m_power_on", 32'(bus.power_on), 32'(m_power));
        chk("m_led", 32'(bus.led), 32'(!m_power));
        chk("m_cmd_valid", 32'(bus.cmd_valid), 32'(q.size() > 0));
        chk("m_level", 32'(bus.level), 32'(q.size()));
        chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
        if (q.size() > 0) chk("m_cmd_data", 32'(bus.cmd_data), 32'(q[0]));
    end

    task automatic send(input logic [7:0] c);
        bus.ir_cmd = c;
        bus.ir_valid = 1'b1;
        @(negedge clk);
        bus.ir_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ir_cmd = 8'h00;
        bus.ir_valid = 1'b0;
        bus.cmd_ready = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_led", 32'(bus.led), 32'd1);
        chk("rst_power", 32'(bus.power_on), 32'd0);
        chk("rst_data", 32'(bus.cmd_data), 32'h00);
        chk("rst_level", 32'(bus.level), 32'd0);
        // standby discards ordinary commands
        send(8'h1F);
        chk("sb_valid", 32'(bus.cmd_valid), 32'd0);
        chk("sb_ovf", 32'(bus.overflow), 32'd0);
        idle(10);
        send(PWR);
        chk("on_power", 32'(bus.power_on), 32'd1);
        chk("on_led", 32'(bus.led), 32'd0);
        idle(10);
        send(8'h12);
        send(8'h34);
        chk("q_level", 32'(bus.level), 32'd2);
        chk("q_data", 32'(bus.cmd_data), 32'h12);
        bus.cmd_ready = 1'b1;
        idle(1);
        chk("pop1_data", 32'(bus.cmd_data), 32'h34);
        idle(1);
        chk("pop2_valid", 32'(bus.cmd_valid), 32'd0);
        bus.cmd_ready = 1'b0;
        // repeat suppression: window reloads on each duplicate
        send(8'h12);
        chk("rep_l1", 32'(bus.level), 32'd1);
        idle(2);
        send(8'h12);
        chk("rep_l2", 32'(bus.level), 32'd1);
        idle(2);
        send(8'h12);
        chk("rep_l3", 32'(bus.level), 32'd1);
        idle(11);
        send(8'h12);
        chk("rep_l4", 32'(bus.level), 32'd2);
        bus.cmd_ready = 1'b1;
        idle(2);
        bus.cmd_ready = 1'b0;
        chk("drain_level", 32'(bus.level), 32'd0);
        // overflow on the fifth code, then drain across the pointer wrap
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level), 32'd4);
        idle(1);
        chk("ovf_end", 32'(bus.overflow), 32'd0);
        bus.cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("wrap_data", 32'(bus.cmd_data), 32'(i));
            idle(1);
        end
        chk("wrap_empty", 32'(bus.cmd_valid), 32'd0);
        bus.cmd_ready = 1'b0;
        // power-off flush with a concurrent pop request
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        chk("fl_pre", 32'(bus.level), 32'd3);
        bus.cmd_ready = 1'b1;
        send(PWR);
        chk("fl_power", 32'(bus.power_on), 32'd0);
        chk("fl_led", 32'(bus.led), 32'd1);
        chk("fl_level", 32'(bus.level), 32'd0);
        chk("fl_valid", 32'(bus.cmd_valid), 32'd0);
        bus.cmd_ready = 1'b0;
        idle(10);
        // asynchronous reset between edges
        send(PWR);
        send(8'h21);
        send(8'h22);
        chk("ar_pre", 32'(bus.level), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_power", 32'(bus.power_on), 32'd0);
        chk("ar_led", 32'(bus.led), 32'd1);
        chk("ar_level", 32'(bus.level), 32'd0);
        chk("ar_valid", 32'(bus.cmd_valid), 32'd0);
        chk("ar_data", 32'(bus.cmd_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send(8'h21);
        chk("ar_sb", 32'(bus.level), 32'd0);
        send(PWR);
        chk("ar_on", 32'(bus.power_on), 32'd1);
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
